// File: rtl/hazard_pkg.sv
// Shared encodings for the forwarding/hazard controller: instruction classes,
// bypass mux selects and controller state.
package hazard_pkg;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_LOAD = 2'b10;
    localparam logic [1:0] CLS_LINK = 2'b11;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_WAIT  = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    function automatic logic writes_reg(input logic [1:0] cls);
        return cls != CLS_NONE;
    endfunction

endpackage

// File: rtl/fwd_sel_lane.sv
// One source operand: match against EX/MEM/WB destinations, pick the bypass
// source by stage priority and flag a load-use dependency on EX.
module fwd_sel_lane
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic          used,
    input  logic [AW-1:0] ex_rd,
    input  logic [1:0]    ex_cls,
    input  logic [AW-1:0] mem_rd,
    input  logic [1:0]    mem_cls,
    input  logic          mem_ready,
    input  logic [AW-1:0] wb_rd,
    input  logic [1:0]    wb_cls,
    output logic [1:0]    sel,
    output logic          load_use
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = used && (rs == ex_rd)  && (ex_rd  != '0) && writes_reg(ex_cls);
    assign mem_hit = used && (rs == mem_rd) && (mem_rd != '0) && writes_reg(mem_cls);
    assign wb_hit  = used && (rs == wb_rd)  && (wb_rd  != '0) && writes_reg(wb_cls);

    always_comb begin
        sel      = FWD_RF;
        load_use = 1'b0;
        // An EX match shadows older stages even when it cannot forward itself
        if (ex_hit) begin
            if (ex_cls == CLS_LOAD) begin
                load_use = 1'b1;
            end else begin
                sel = FWD_EX;
            end
        end else if (mem_hit) begin
            if (mem_cls != CLS_LOAD || mem_ready) begin
                sel = FWD_MEM;
            end
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller beside the ID/EX boundary: operand bypass
// selects, load-use stall/bubble, memory freeze with sticky timeout.
//
// state       | meaning
// ST_RUN      | normal issue; load-use hazards are detected here
// ST_LU_WAIT  | bubble inserted, the load now sits in MEM
// ST_MEM_WAIT | pipeline frozen waiting for mem_ready
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        ex_rd,
    input  logic [AW-1:0]        mem_rd,
    input  logic [AW-1:0]        wb_rd,
    input  logic [1:0]           ex_cls,
    input  logic [1:0]           mem_cls,
    input  logic [1:0]           wb_cls,
    input  logic [NSRC*AW-1:0]   rs_addr,
    input  logic [NSRC-1:0]      rs_used,
    input  logic                 mem_ready,
    input  logic                 flush,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 bubble,
    output logic                 freeze,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [1:0]           state
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_TC  = WW'(MAX_WAIT - 1);

    state_t          state_q;
    state_t          state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [NSRC-1:0] lu_vec;
    logic            lu_any;
    logic            mem_busy;

    for (genvar g = 0; g < NSRC; g++) begin : g_lane
        fwd_sel_lane #(.AW(AW)) u_lane (
            .rs        (rs_addr[g*AW +: AW]),
            .used      (rs_used[g]),
            .ex_rd     (ex_rd),
            .ex_cls    (ex_cls),
            .mem_rd    (mem_rd),
            .mem_cls   (mem_cls),
            .mem_ready (mem_ready),
            .wb_rd     (wb_rd),
            .wb_cls    (wb_cls),
            .sel       (fwd_sel[2*g +: 2]),
            .load_use  (lu_vec[g])
        );
    end

    assign lu_any   = |lu_vec;
    assign mem_busy = (mem_cls == CLS_LOAD) && !mem_ready;
    assign state    = state_q;

    // Freeze wins over flush and load-use in every state; a new load-use
    // stall is only raised from RUN, and flush suppresses it there.
    always_comb begin
        freeze    = mem_busy;
        stall     = 1'b0;
        bubble    = 1'b0;
        state_nxt = ST_RUN;
        if (mem_busy) begin
            stall     = 1'b1;
            state_nxt = ST_MEM_WAIT;
        end else if (state_q == ST_RUN && lu_any && !flush) begin
            stall     = 1'b1;
            bubble    = 1'b1;
            state_nxt = ST_LU_WAIT;
        end
    end

    // wait_cnt counts every consecutive frozen cycle, including the one that
    // enters MEM_WAIT, and clears on the first cycle memory is not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state_q <= state_nxt;
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (mem_busy) begin
                if (wait_cnt >= WAIT_TC) begin
                    mem_timeout <= 1'b1;
                end
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with a behavioural model checked on
// every negative clock edge plus hand-computed literal checkpoints.
module tb_hazard_fwd_ctrl;

    localparam int AW       = 5;
    localparam int NSRC     = 2;
    localparam int CNT_W    = 16;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AW-1:0]        ex_rd, mem_rd, wb_rd;
    logic [1:0]           ex_cls, mem_cls, wb_cls;
    logic [NSRC*AW-1:0]   rs_addr;
    logic [NSRC-1:0]      rs_used;
    logic                 mem_ready, flush;
    logic [2*NSRC-1:0]    fwd_sel;
    logic                 stall, bubble, freeze, mem_timeout;
    logic [CNT_W-1:0]     stall_cnt;
    logic [1:0]           state;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state = 0;
    int m_scnt  = 0;
    int m_wait  = 0;
    bit m_to    = 1'b0;

    logic [2*NSRC-1:0] e_fwd;
    bit e_stall, e_bubble, e_freeze;
    int e_next;

    hazard_fwd_ctrl #(
        .AW(AW), .NSRC(NSRC), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_cls(ex_cls), .mem_cls(mem_cls), .wb_cls(wb_cls),
        .rs_addr(rs_addr), .rs_used(rs_used),
        .mem_ready(mem_ready), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .freeze(freeze),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Walk the stages oldest-priority-last; the first matching stage decides.
    function automatic void model_eval();
        logic [AW-1:0] rd[3];
        logic [1:0]    cls[3];
        logic [AW-1:0] a;
        bit lu_any;
        bit busy;
        int src;
        rd[0] = ex_rd;  rd[1] = mem_rd;  rd[2] = wb_rd;
        cls[0] = ex_cls; cls[1] = mem_cls; cls[2] = wb_cls;
        lu_any = 0;
        e_fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            a = rs_addr[i*AW +: AW];
            src = 0;
            for (int s = 0; s < 3; s++) begin
                if (src == 0 && rs_used[i] && a == rd[s] && rd[s] != 0 && cls[s] != 0) begin
                    if (s == 0 && cls[s] == 2) begin
                        lu_any = 1;
                        src = -1;
                    end else if (s == 1 && cls[s] == 2 && !mem_ready) begin
                        src = -1;
                    end else begin
                        src = s + 1;
                    end
                end
            end
            if (src > 0) e_fwd[2*i +: 2] = 2'(src);
        end
        busy     = (mem_cls == 2) && !mem_ready;
        e_freeze = busy;
        e_bubble = !busy && m_state == 0 && lu_any && !flush;
        e_stall  = busy || e_bubble;
        e_next   = busy ? 2 : (e_bubble ? 1 : 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_scnt = 0; m_wait = 0; m_to = 0;
        end else begin
            model_eval();
            if (e_stall && m_scnt < CNT_MAX) m_scnt++;
            if (e_freeze) begin
                m_wait++;
                if (m_wait >= MAX_WAIT) m_to = 1;
            end else begin
                m_wait = 0;
            end
            m_state = e_next;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            model_eval();
            check("fwd_sel", fwd_sel, e_fwd);
            check("stall", stall, e_stall);
            check("bubble", bubble, e_bubble);
            check("freeze", freeze, e_freeze);
            check("state", state, m_state);
            check("stall_cnt", stall_cnt, m_scnt);
            check("mem_timeout", mem_timeout, m_to);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_cls = 0; mem_cls = 0; wb_cls = 0;
        rs_addr = 0; rs_used = 0; mem_ready = 0; flush = 0;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [1:0] used);
        rs_addr = {a1, a0};
        rs_used = used;
    endtask

    initial begin
        idle();
        repeat (2) step();
        rst = 0;
        #1 check("lit_rst_state", state, 0);
        check("lit_rst_cnt", stall_cnt, 0);
        check("lit_rst_to", mem_timeout, 0);
        check("lit_rst_stall", stall, 0);

        // ALU forwarding and stage priority
        ex_cls = 1; ex_rd = 5; set_rs(5, 0, 2'b01);
        #1 check("lit_alu_ex", fwd_sel, 4'b0001);
        check("lit_alu_nostall", stall, 0);
        mem_cls = 1; mem_rd = 5; wb_cls = 1; wb_rd = 5;
        #1 check("lit_ex_wins", fwd_sel, 4'b0001);
        step();
        ex_cls = 0;
        #1 check("lit_mem_alu", fwd_sel, 4'b0010);
        mem_cls = 0;
        #1 check("lit_wb_alu", fwd_sel, 4'b0011);
        wb_cls = 2; set_rs(5, 5, 2'b11);
        #1 check("lit_wb_load_both", fwd_sel, 4'b1111);
        ex_cls = 3;
        #1 check("lit_link_ex", fwd_sel, 4'b0101);
        step();

        // Load-use resolved on the next cycle
        idle(); ex_cls = 2; ex_rd = 7; set_rs(0, 7, 2'b10);
        #1 check("lit_lu_stall", stall, 1);
        check("lit_lu_bubble", bubble, 1);
        check("lit_lu_fwd", fwd_sel, 0);
        step();
        check("lit_lu_state", state, 1);
        idle(); mem_cls = 2; mem_rd = 7; mem_ready = 1; set_rs(0, 7, 2'b10);
        #1 check("lit_lu_release", stall, 0);
        check("lit_lu_memfwd", fwd_sel, 4'b1000);
        step();
        idle();
        #1 check("lit_lu_back_run", state, 0);
        check("lit_lu_cnt", stall_cnt, 1);

        // Load-use followed by three busy memory cycles
        ex_cls = 2; ex_rd = 7; set_rs(0, 7, 2'b10);
        step();
        idle(); mem_cls = 2; mem_rd = 7; set_rs(0, 7, 2'b10);
        #1 check("lit_lu_freeze", freeze, 1);
        check("lit_lu_freeze_nobubble", bubble, 0);
        step();
        check("lit_memwait_state", state, 2);
        repeat (2) step();
        mem_ready = 1;
        #1 check("lit_ready_unfreeze", freeze, 0);
        check("lit_ready_fwd", fwd_sel, 4'b1000);
        step();
        idle();
        #1 check("lit_ready_run", state, 0);
        check("lit_ready_cnt", stall_cnt, 5);
        check("lit_no_timeout", mem_timeout, 0);

        // Timeout after MAX_WAIT frozen cycles, sticky until reset
        mem_cls = 2; mem_rd = 9;
        repeat (3) step();
        check("lit_to_before", mem_timeout, 0);
        step();
        check("lit_to_set", mem_timeout, 1);
        repeat (2) step();
        mem_ready = 1;
        step();
        idle();
        repeat (2) step();
        check("lit_to_sticky", mem_timeout, 1);
        check("lit_to_cnt", stall_cnt, 11);
        rst = 1;
        step();
        rst = 0;
        check("lit_rst_to_clear", mem_timeout, 0);
        check("lit_rst_cnt_clear", stall_cnt, 0);

        // Zero register, unused operands, class 00, flush handling
        ex_cls = 1; ex_rd = 0; set_rs(0, 0, 2'b11);
        #1 check("lit_rd0", fwd_sel, 0);
        ex_rd = 5; set_rs(5, 5, 2'b00);
        #1 check("lit_unused", fwd_sel, 0);
        ex_cls = 2; ex_rd = 0; set_rs(0, 0, 2'b11);
        #1 check("lit_load_rd0", stall, 0);
        idle(); mem_cls = 1;
        #1 check("lit_alu_mem_nofreeze", freeze, 0);
        idle(); ex_cls = 2; ex_rd = 3; set_rs(3, 0, 2'b01); flush = 1;
        #1 check("lit_flush_run", stall, 0);
        step();
        check("lit_flush_run_state", state, 0);
        flush = 0;
        #1 check("lit_lu2_stall", stall, 1);
        step();
        idle(); mem_cls = 2; mem_rd = 3; mem_ready = 1; flush = 1; set_rs(3, 0, 2'b01);
        #1 check("lit_flush_lu", stall, 0);
        check("lit_flush_lu_fwd", fwd_sel, 4'b0010);
        step();
        idle();
        #1 check("lit_flush_lu_run", state, 0);
        mem_cls = 2; flush = 1;
        #1 check("lit_flush_busy", freeze, 1);
        step();
        idle();
        step();

        // Saturation of the stall counter, then reset out of MEM_WAIT
        mem_cls = 2;
        repeat (CNT_MAX + 5) step();
        check("lit_cnt_sat", stall_cnt, 16'hFFFF);
        check("lit_sat_state", state, 2);
        idle(); rst = 1;
        step();
        rst = 0;
        #1 check("lit_rst_mid_state", state, 0);
        check("lit_rst_mid_stall", stall, 0);
        check("lit_rst_mid_freeze", freeze, 0);
        check("lit_rst_mid_cnt", stall_cnt, 0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
